// File: rtl/c3aibadapt_avmm_pkg.sv
// Shared types and helpers for the user-side AVMM width-expansion adapter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package c3aibadapt_avmm_pkg;

  // Command-path state: IDLE has nothing presented to the fabric, BUSY has a command presented.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } avmm_state_e;

  // Returns 1 when fabric byte byte_idx belongs to narrow lane `lane` (nbytes bytes per lane).
  function automatic logic lane_byte_sel(input int lane, input int nbytes, input int byte_idx);
    return (byte_idx >= lane * nbytes) && (byte_idx < (lane + 1) * nbytes);
  endfunction

endpackage

// File: rtl/c3aibadapt_avmm_lane_fifo.sv
// Lane-index FIFO tracking outstanding reads so returning wide data can be narrowed.
// Latency: head visible the cycle after push; pop is same-cycle on the head entry.
// Backpressure: pushes while full and pops while empty are ignored; the owner must gate them.
module c3aibadapt_avmm_lane_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                       i_usr_avmm_clk,
  input  logic                       i_usr_avmm_rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge i_usr_avmm_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap modulo DEPTH (DEPTH need not be a power of two); count tracks occupancy.
  always_ff @(posedge i_usr_avmm_clk) begin
    if (i_usr_avmm_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/c3aibadapt_avmm_usr_wexp.sv
// Narrow user AVMM to wide fabric AVMM adapter: lane-steered writes, lane-extracted read returns.
// Latency: fabric command registered 1 cycle after accept; read data returned with zero latency.
// Backpressure: fabric waitrequest passes through while busy; reads also stall when RD_DEPTH reads are outstanding.
module c3aibadapt_avmm_usr_wexp
  import c3aibadapt_avmm_pkg::*;
#(
  parameter int NARROW_W = 8,
  parameter int WIDE_W   = 32,
  parameter int ADDR_W   = 19,
  parameter int RD_DEPTH = 4
) (
  input  logic                                      i_usr_avmm_clk,
  input  logic                                      i_usr_avmm_rst,
  input  logic                                      i_usr_avmm_read,
  input  logic                                      i_usr_avmm_write,
  input  logic [NARROW_W-1:0]                       i_usr_avmm_wdata,
  input  logic [ADDR_W-1:0]                         i_usr_avmm_addr,
  output logic [NARROW_W-1:0]                       o_usr_avmm_rdata,
  output logic                                      o_usr_avmm_readdatavalid,
  output logic                                      o_usr_avmm_writedone,
  output logic                                      o_usr_avmm_waitrequest,
  output logic [$clog2(RD_DEPTH+1)-1:0]             o_usr_avmm_rd_pending,
  output logic                                      o_usr_avmm_rd_err,
  output logic                                      o_usr_avmmw_read,
  output logic                                      o_usr_avmmw_write,
  output logic [ADDR_W-$clog2(WIDE_W/NARROW_W)-1:0] o_usr_avmmw_addr,
  output logic [WIDE_W-1:0]                         o_usr_avmmw_wdata,
  output logic [WIDE_W/8-1:0]                       o_usr_avmmw_byte_en,
  input  logic [WIDE_W-1:0]                         i_usr_avmmw_rdata,
  input  logic                                      i_usr_avmmw_rdatavalid,
  input  logic                                      i_usr_avmmw_waitrequest
);

  localparam int RATIO = WIDE_W / NARROW_W;
  localparam int LR    = $clog2(RATIO);
  localparam int LW    = (LR > 0) ? LR : 1;
  localparam int BW    = WIDE_W / 8;
  localparam int NB    = NARROW_W / 8;

  avmm_state_e   state_q;
  logic          accept;
  logic          acc_rd;
  logic          acc_wr;
  logic          fab_accept;
  logic          rd_full;
  logic          rd_empty;
  logic          rd_pop;
  logic [LW-1:0] lane_in;
  logic [LW-1:0] head_lane;
  logic [BW-1:0] be_nxt;
  logic [NARROW_W-1:0] rd_sel;

  // Reads stall when the tracking FIFO is full; a same-cycle return does not free the slot early.
  assign o_usr_avmm_waitrequest = ((state_q == ST_BUSY) & i_usr_avmmw_waitrequest)
                                | (i_usr_avmm_read & rd_full);
  assign accept     = (i_usr_avmm_read | i_usr_avmm_write) & ~o_usr_avmm_waitrequest;
  assign acc_rd     = accept & i_usr_avmm_read;
  assign acc_wr     = accept & i_usr_avmm_write & ~i_usr_avmm_read;
  assign fab_accept = (state_q == ST_BUSY) & ~i_usr_avmmw_waitrequest;
  assign lane_in    = i_usr_avmm_addr[LR-1:0];

  // Byte enables cover only the bytes of the addressed narrow lane.
  always_comb begin
    be_nxt = '0;
    for (int b = 0; b < BW; b++) begin
      be_nxt[b] = lane_byte_sel(int'(lane_in), NB, b);
    end
  end

  // Command FSM with the fabric command registers; held stable while the fabric stalls.
  always_ff @(posedge i_usr_avmm_clk) begin
    if (i_usr_avmm_rst) begin
      state_q             <= ST_IDLE;
      o_usr_avmmw_read    <= 1'b0;
      o_usr_avmmw_write   <= 1'b0;
      o_usr_avmmw_addr    <= '0;
      o_usr_avmmw_wdata   <= '0;
      o_usr_avmmw_byte_en <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_q <= ST_BUSY;
        ST_BUSY: if (!i_usr_avmmw_waitrequest) state_q <= accept ? ST_BUSY : ST_IDLE;
      endcase
      if (accept) begin
        o_usr_avmmw_read    <= acc_rd;
        o_usr_avmmw_write   <= acc_wr;
        o_usr_avmmw_addr    <= i_usr_avmm_addr[ADDR_W-1:LR];
        o_usr_avmmw_wdata   <= {RATIO{i_usr_avmm_wdata}};
        o_usr_avmmw_byte_en <= be_nxt;
      end else if (fab_accept) begin
        o_usr_avmmw_read  <= 1'b0;
        o_usr_avmmw_write <= 1'b0;
      end
    end
  end

  // One-cycle status pulses: write completion and stray read returns.
  always_ff @(posedge i_usr_avmm_clk) begin
    if (i_usr_avmm_rst) begin
      o_usr_avmm_writedone <= 1'b0;
      o_usr_avmm_rd_err    <= 1'b0;
    end else begin
      o_usr_avmm_writedone <= fab_accept & o_usr_avmmw_write;
      o_usr_avmm_rd_err    <= i_usr_avmmw_rdatavalid & rd_empty;
    end
  end

  // A return arriving during reset is discarded along with the pending reads.
  assign rd_pop = i_usr_avmmw_rdatavalid & ~rd_empty & ~i_usr_avmm_rst;

  c3aibadapt_avmm_lane_fifo #(
    .DEPTH (RD_DEPTH),
    .WIDTH (LW)
  ) u_lane_fifo (
    .i_usr_avmm_clk (i_usr_avmm_clk),
    .i_usr_avmm_rst (i_usr_avmm_rst),
    .push           (acc_rd),
    .push_dat       (lane_in),
    .pop            (rd_pop),
    .head_dat       (head_lane),
    .count          (o_usr_avmm_rd_pending),
    .empty          (rd_empty),
    .full           (rd_full)
  );

  // Select the narrow lane recorded for the oldest outstanding read.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (head_lane == LW'(i)) rd_sel = i_usr_avmmw_rdata[i*NARROW_W +: NARROW_W];
    end
  end

  assign o_usr_avmm_readdatavalid = rd_pop;
  assign o_usr_avmm_rdata         = rd_pop ? rd_sel : '0;

endmodule
